// File: rtl/l2_sync_reservation_pkg.sv
// Shared types for the L2 load-linked/store-conditional reservation tracker.
// Optional build macro: L2_SYNC_TIMEOUT_EN (reservation lifetime counters).
`ifndef NUM_CORES
`define NUM_CORES 2
`endif
`ifndef THREADS_PER_CORE
`define THREADS_PER_CORE 4
`endif

package l2_sync_reservation_pkg;

  typedef enum logic [2:0] {
    L2REQ_LOAD,
    L2REQ_STORE,
    L2REQ_WRITEBACK,
    L2REQ_FLUSH,
    L2REQ_INVALIDATE,
    L2REQ_IINVALIDATE,
    L2REQ_LOAD_SYNC,
    L2REQ_STORE_SYNC
  } l2req_packet_type_t;

  // Keeps id fields at least one bit wide for single-core/single-thread builds.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SYNC_RES_ENTRIES = `NUM_CORES * `THREADS_PER_CORE;
  localparam int CORE_ID_WIDTH    = clog2_min1(`NUM_CORES);
  localparam int THREAD_ID_WIDTH  = clog2_min1(`THREADS_PER_CORE);

  typedef struct packed {
    logic        valid;
    logic [25:0] line_addr;
  } sync_res_entry_t;

endpackage

// File: rtl/l2_sync_reservation_entry.sv
// One hardware thread's reservation: valid flag, line address, address compare.
// With L2_SYNC_TIMEOUT_EN an age counter retires the reservation after TIMEOUT_CYCLES.
module sync_reservation_entry #(
  parameter int LINE_ADDR_WIDTH = 26
`ifdef L2_SYNC_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_set,
  input  logic                       i_clr,
  input  logic [LINE_ADDR_WIDTH-1:0] i_addr,
  output logic                       o_live,
  output logic                       o_match,
  output logic                       o_valid_d
);

  logic                       r_valid;
  logic [LINE_ADDR_WIDTH-1:0] r_addr;
  logic                       w_expire;

`ifdef L2_SYNC_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [AGE_W-1:0] r_age;

  // At the limit the reservation is already dead for this cycle's request.
  assign w_expire = r_valid && (r_age == AGE_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset)                    r_age <= '0;
    else if (i_set)               r_age <= '0;
    else if (r_valid && !w_expire) r_age <= r_age + 1'b1;
  end
`else
  assign w_expire = 1'b0;
`endif

  assign o_live    = r_valid & ~w_expire;
  assign o_match   = r_valid && (r_addr == i_addr);
  assign o_valid_d = i_set | (r_valid & ~i_clr & ~w_expire);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_valid <= o_valid_d;
      if (i_set) r_addr <= i_addr;
    end
  end

endmodule

// File: rtl/l2_sync_reservation.sv
// L2 sync-store reservation tracker: one entry per thread, decides STORE_SYNC success.
// Optional build macro: L2_SYNC_TIMEOUT_EN.
`ifndef NUM_CORES
`define NUM_CORES 2
`endif
`ifndef THREADS_PER_CORE
`define THREADS_PER_CORE 4
`endif

module l2_sync_reservation
  import l2_sync_reservation_pkg::*;
#(
  parameter int NUM_CORES        = `NUM_CORES,
  parameter int THREADS_PER_CORE = `THREADS_PER_CORE,
  parameter int LINE_ADDR_WIDTH  = 26,
  parameter int TIMEOUT_CYCLES   = 1024
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           req_valid,
  input  l2req_packet_type_t                             req_type,
  input  logic [clog2_min1(NUM_CORES)-1:0]               req_core,
  input  logic [clog2_min1(THREADS_PER_CORE)-1:0]        req_thread,
  input  logic [LINE_ADDR_WIDTH-1:0]                     req_line_addr,
  output logic                                           rsp_valid,
  output logic                                           rsp_success,
  output l2req_packet_type_t                             rsp_type,
  output logic [$clog2(NUM_CORES*THREADS_PER_CORE):0]    active_count
);

  localparam int ENTRIES = NUM_CORES * THREADS_PER_CORE;
  localparam int IDX_W   = clog2_min1(ENTRIES);
  localparam int CNT_W   = $clog2(ENTRIES) + 1;

  logic [IDX_W-1:0]   w_idx;
  logic [ENTRIES-1:0] w_own, w_live, w_match, w_set, w_clr, w_valid_d;
  logic               w_is_ld, w_is_ss, w_is_st, w_accept, w_success;
  logic [CNT_W-1:0]   w_popcnt;

  assign w_idx    = IDX_W'(req_core) * IDX_W'(THREADS_PER_CORE) + IDX_W'(req_thread);
  assign w_is_ld  = req_valid && (req_type == L2REQ_LOAD_SYNC);
  assign w_is_ss  = req_valid && (req_type == L2REQ_STORE_SYNC);
  assign w_is_st  = req_valid && (req_type == L2REQ_STORE);
  assign w_accept = w_is_ld | w_is_ss | w_is_st;

  assign w_success = |(w_own & w_live & w_match);
  assign w_set     = w_is_ld ? w_own : '0;
  // A winning sync store kills every reservation on the line; a losing one only its own.
  assign w_clr     = (w_is_st ? w_match : '0)
                   | (w_is_ss ? (w_success ? w_match : w_own) : '0);

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    assign w_own[i] = (w_idx == IDX_W'(i));

    sync_reservation_entry #(
      .LINE_ADDR_WIDTH(LINE_ADDR_WIDTH)
`ifdef L2_SYNC_TIMEOUT_EN
      , .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
`endif
    ) u_ent (
      .clk      (clk),
      .reset    (reset),
      .i_set    (w_set[i]),
      .i_clr    (w_clr[i]),
      .i_addr   (req_line_addr),
      .o_live   (w_live[i]),
      .o_match  (w_match[i]),
      .o_valid_d(w_valid_d[i])
    );
  end

`ifndef L2_SYNC_TIMEOUT_EN
  // Lifetime only matters to the timeout build.
  if (TIMEOUT_CYCLES < 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < ENTRIES; i++) w_popcnt = w_popcnt + CNT_W'(w_valid_d[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid    <= 1'b0;
      rsp_success  <= 1'b0;
      rsp_type     <= L2REQ_LOAD;
      active_count <= '0;
    end else begin
      rsp_valid    <= w_accept;
      rsp_success  <= w_accept && (w_is_ss ? w_success : 1'b1);
      if (w_accept) rsp_type <= req_type;
      active_count <= w_popcnt;
    end
  end

endmodule

// File: tb/tb_l2_sync_reservation.sv
// Self-checking bench: timestamp-based reservation model plus directed literal checks.
`ifndef NUM_CORES
`define NUM_CORES 2
`endif
`ifndef THREADS_PER_CORE
`define THREADS_PER_CORE 4
`endif

module tb_l2_sync_reservation;
  import l2_sync_reservation_pkg::*;

  localparam int NC   = 2;
  localparam int TPC  = 4;
  localparam int NE   = NC * TPC;
  localparam int TOUT = 8;
`ifdef L2_SYNC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               reset;
  logic               req_valid;
  l2req_packet_type_t req_type;
  logic [0:0]         req_core;
  logic [1:0]         req_thread;
  logic [25:0]        req_line_addr;
  logic               rsp_valid, rsp_success;
  l2req_packet_type_t rsp_type;
  logic [3:0]         active_count;

  l2_sync_reservation #(
    .NUM_CORES(NC), .THREADS_PER_CORE(TPC), .LINE_ADDR_WIDTH(26), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_type(req_type),
    .req_core(req_core), .req_thread(req_thread), .req_line_addr(req_line_addr),
    .rsp_valid(rsp_valid), .rsp_success(rsp_success), .rsp_type(rsp_type),
    .active_count(active_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input longint got, input longint exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // Model: a reservation is a (thread, line, edge-set) record; it is alive while
  // fewer than TOUT+1 edges have passed since it was set (timeout build only).
  bit                 m_valid [NE];
  logic [25:0]        m_addr  [NE];
  int                 m_set   [NE];
  int                 t = 0;
  bit                 exp_v, exp_s;
  l2req_packet_type_t exp_t;
  int                 exp_cnt;

  function automatic bit alive(input int i);
    return m_valid[i] && (!TO_EN || (t - m_set[i]) <= TOUT);
  endfunction

  always @(posedge clk) begin
    int idx;
    bit ok;
    t++;
    exp_v = 1'b0;
    exp_s = 1'b0;
    if (reset) begin
      for (int i = 0; i < NE; i++) m_valid[i] = 1'b0;
      exp_t = L2REQ_LOAD;
    end else if (req_valid && (req_type == L2REQ_LOAD_SYNC || req_type == L2REQ_STORE_SYNC ||
                               req_type == L2REQ_STORE)) begin
      idx   = int'(req_core) * TPC + int'(req_thread);
      exp_v = 1'b1;
      exp_s = 1'b1;
      exp_t = req_type;
      if (req_type == L2REQ_LOAD_SYNC) begin
        m_valid[idx] = 1'b1;
        m_addr[idx]  = req_line_addr;
        m_set[idx]   = t;
      end else begin
        ok = (req_type == L2REQ_STORE) || (alive(idx) && m_addr[idx] == req_line_addr);
        if (req_type == L2REQ_STORE_SYNC) begin
          exp_s = ok;
          m_valid[idx] = 1'b0;
        end
        if (ok)
          for (int i = 0; i < NE; i++)
            if (m_addr[i] == req_line_addr) m_valid[i] = 1'b0;
      end
    end
    exp_cnt = 0;
    for (int i = 0; i < NE; i++) if (alive(i)) exp_cnt++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model rsp_valid", rsp_valid, exp_v);
      check("model active_count", active_count, exp_cnt);
      if (exp_v) begin
        check("model rsp_success", rsp_success, exp_s);
        check("model rsp_type", rsp_type, exp_t);
      end
    end
  end

  // Drives one cycle from a negedge; returns at the next negedge with the response visible.
  task automatic drive(input logic rst, input logic v, input l2req_packet_type_t ty,
                       input int core, input int thr, input logic [25:0] a);
    reset = rst; req_valid = v; req_type = ty;
    req_core = 1'(core); req_thread = 2'(thr); req_line_addr = a;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
  endtask

  task automatic send(input l2req_packet_type_t ty, input int core, input int thr,
                      input logic [25:0] a);
    drive(1'b0, 1'b1, ty, core, thr, a);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, L2REQ_LOAD, 0, 0, 26'h0);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_type = L2REQ_LOAD;
    req_core = '0; req_thread = '0; req_line_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_success", rsp_success, 0);
    check("reset rsp_type", rsp_type, L2REQ_LOAD);
    check("reset active_count", active_count, 0);
    chk_en = 1'b1;

    // basic success
    send(L2REQ_LOAD_SYNC, 0, 0, 26'h4);
    check("basic ld count", active_count, 1);
    send(L2REQ_STORE_SYNC, 0, 0, 26'h4);
    check("basic ss success", rsp_success, 1);
    check("basic ss count", active_count, 0);

    // contention on one line
    send(L2REQ_LOAD_SYNC, 0, 1, 26'h4);
    send(L2REQ_LOAD_SYNC, 0, 2, 26'h4);
    check("contend count", active_count, 2);
    send(L2REQ_STORE_SYNC, 0, 1, 26'h4);
    check("contend first", rsp_success, 1);
    send(L2REQ_STORE_SYNC, 0, 2, 26'h4);
    check("contend second", rsp_success, 0);
    check("contend count end", active_count, 0);

    // foreign store kills reservation; store to another line does not
    send(L2REQ_LOAD_SYNC, 0, 0, 26'h10);
    send(L2REQ_STORE, 1, 0, 26'h10);
    check("store success", rsp_success, 1);
    check("store type", rsp_type, L2REQ_STORE);
    send(L2REQ_STORE_SYNC, 0, 0, 26'h10);
    check("foreign kill", rsp_success, 0);
    send(L2REQ_LOAD_SYNC, 0, 0, 26'h10);
    send(L2REQ_STORE, 1, 0, 26'h11);
    send(L2REQ_STORE_SYNC, 0, 0, 26'h10);
    check("other line store", rsp_success, 1);

    // address mismatch, retry, overwrite
    send(L2REQ_LOAD_SYNC, 0, 0, 26'h20);
    send(L2REQ_STORE_SYNC, 0, 0, 26'h21);
    check("mismatch", rsp_success, 0);
    send(L2REQ_STORE_SYNC, 0, 0, 26'h20);
    check("retry after fail", rsp_success, 0);
    send(L2REQ_LOAD_SYNC, 0, 0, 26'h20);
    send(L2REQ_LOAD_SYNC, 0, 0, 26'h30);
    check("overwrite count", active_count, 1);
    send(L2REQ_STORE_SYNC, 0, 0, 26'h20);
    check("overwrite", rsp_success, 0);
    check("overwrite count end", active_count, 0);

    // ignored type and unqualified request leave state alone
    send(L2REQ_LOAD_SYNC, 1, 3, 26'h40);
    send(L2REQ_WRITEBACK, 1, 3, 26'h40);
    check("ignored rsp_valid", rsp_valid, 0);
    drive(1'b0, 1'b0, L2REQ_LOAD_SYNC, 1, 2, 26'h50);
    check("no valid rsp_valid", rsp_valid, 0);
    send(L2REQ_STORE_SYNC, 1, 3, 26'h40);
    check("after ignored", rsp_success, 1);
    send(L2REQ_STORE_SYNC, 1, 2, 26'h50);
    check("unqualified ld", rsp_success, 0);

    // max line address
    send(L2REQ_LOAD_SYNC, 1, 1, 26'h3FFFFFF);
    send(L2REQ_STORE_SYNC, 1, 1, 26'h3FFFFFF);
    check("max addr", rsp_success, 1);

    // reset mid-stream discards the concurrent request
    send(L2REQ_LOAD_SYNC, 0, 0, 26'h4);
    check("pre-reset rsp_valid", rsp_valid, 1);
    drive(1'b1, 1'b1, L2REQ_LOAD_SYNC, 1, 3, 26'h8);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset mid count", active_count, 0);
    send(L2REQ_STORE_SYNC, 0, 0, 26'h4);
    check("post-reset ss", rsp_success, 0);
    check("post-reset count", active_count, 0);
    send(L2REQ_STORE_SYNC, 1, 3, 26'h8);
    check("discarded ld", rsp_success, 0);

`ifdef L2_SYNC_TIMEOUT_EN
    send(L2REQ_LOAD_SYNC, 0, 0, 26'h4);
    idle(7);
    send(L2REQ_STORE_SYNC, 0, 0, 26'h4);
    check("timeout 7 idle", rsp_success, 1);
    send(L2REQ_LOAD_SYNC, 0, 0, 26'h4);
    idle(8);
    send(L2REQ_STORE_SYNC, 0, 0, 26'h4);
    check("timeout 8 idle", rsp_success, 0);
`else
    send(L2REQ_LOAD_SYNC, 0, 0, 26'h4);
    idle(20);
    check("persist count", active_count, 1);
    send(L2REQ_STORE_SYNC, 0, 0, 26'h4);
    check("persist", rsp_success, 1);
`endif

    idle(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
